// File: rtl/seq_det_pkg.sv
// Shared "1101" overlapping Mealy detector: state encoding and single-step
// next-state function applied to whichever channel context is granted.
package seq_det_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } det_state_e;

  localparam logic [3:0] PATTERN = 4'b1101;

  typedef struct packed {
    det_state_e nxt;
    logic       hit;
  } det_step_t;

  // One detector step; a hit leaves S1 so the final 1 seeds the next match.
  function automatic det_step_t next_state(input det_state_e state, input logic x);
    det_step_t r;
    r.nxt = S0;
    r.hit = 1'b0;
    unique case (state)
      S0: r.nxt = x ? S1 : S0;
      S1: r.nxt = x ? S2 : S0;
      S2: r.nxt = x ? S2 : S3;
      S3: begin
        r.nxt = x ? S1 : S0;
        r.hit = (x == PATTERN[0]);
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seq_det_sched_if.sv
// Channel bit/grant bus, hit event and counter readback of seq_det_sched.
interface seq_det_sched_if #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CH_W  = 2,
  parameter int unsigned CNT_W = 8
);
  logic [N_CH-1:0]  req;
  logic [N_CH-1:0]  din;
  logic [N_CH-1:0]  gnt;
  logic [N_CH-1:0]  clr_ch;
  logic             hit_vld;
  logic [CH_W-1:0]  hit_ch;
  logic [CH_W-1:0]  cnt_sel;
  logic [CNT_W-1:0] cnt_rd;

  modport master (
    output req, din, clr_ch, cnt_sel,
    input  gnt, hit_vld, hit_ch, cnt_rd
  );

  modport slave (
    input  req, din, clr_ch, cnt_sel,
    output gnt, hit_vld, hit_ch, cnt_rd
  );
endinterface

// File: rtl/seq_det_sched_rr_arbiter.sv
// Round-robin pick of the first eligible channel at or after ptr, with wrap.
module rr_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] g
);

  int unsigned idx;

  // Scan from the farthest offset down so the nearest eligible one wins.
  always_comb begin
    gnt = '0;
    g   = '0;
    idx = 0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      idx = (32'(ptr) + 32'(i)) % N;
      if (eligible[W'(idx)]) begin
        gnt           = '0;
        gnt[W'(idx)]  = 1'b1;
        g             = W'(idx);
      end
    end
  end

endmodule

// File: rtl/seq_det_sched.sv
// Time-shared "1101" detector over N_CH serial channels with per-channel
// saved contexts, registered hit events and saturating match counters.
module seq_det_sched
  import seq_det_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CH_W  = 2,
  parameter int unsigned CNT_W = 8
) (
  input logic           clk,
  input logic           rst,
  seq_det_sched_if.slave bus
);

  logic [N_CH-1:0]  eligible;
  logic [N_CH-1:0]  gnt_c;
  logic [CH_W-1:0]  g;
  logic [CH_W-1:0]  ptr;
  logic             granted;
  det_step_t        step;
  det_state_e       ctx [N_CH];
  logic [CNT_W-1:0] cnt [N_CH];
  logic             hit_vld_q;
  logic [CH_W-1:0]  hit_ch_q;
  logic [CNT_W-1:0] cnt_rd_c;

  // A channel being cleared is never granted in the same cycle.
  assign eligible = bus.req & ~bus.clr_ch;

  rr_arbiter #(.N(N_CH), .W(CH_W)) u_arb (
    .eligible (eligible),
    .ptr      (ptr),
    .gnt      (gnt_c),
    .g        (g)
  );

  assign granted = rst & (|gnt_c);
  assign bus.gnt = rst ? gnt_c : '0;
  assign step    = next_state(ctx[g], bus.din[g]);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < int'(N_CH); k++) begin
        ctx[k] <= S0;
        cnt[k] <= '0;
      end
      ptr       <= '0;
      hit_vld_q <= 1'b0;
      hit_ch_q  <= '0;
    end else begin
      hit_vld_q <= 1'b0;
      for (int k = 0; k < int'(N_CH); k++) begin
        if (bus.clr_ch[k]) begin
          ctx[k] <= S0;
          cnt[k] <= '0;
        end
      end
      if (granted) begin
        ctx[g] <= step.nxt;
        ptr    <= (g == CH_W'(N_CH - 1)) ? '0 : g + 1'b1;
        if (step.hit) begin
          hit_vld_q <= 1'b1;
          hit_ch_q  <= g;
          if (cnt[g] != '1) cnt[g] <= cnt[g] + 1'b1;
        end
      end
    end
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    cnt_rd_c = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      if (bus.cnt_sel == CH_W'(k)) cnt_rd_c = cnt[k];
    end
  end

  assign bus.hit_vld = hit_vld_q;
  assign bus.hit_ch  = hit_ch_q;
  assign bus.cnt_rd  = cnt_rd_c;

endmodule
